// File: rtl/elliptic_curve_structs.sv
//------------------------------------------------------------------------------
// elliptic_curve_structs
// Curve point / scalar types shared by the point-multiplication datapath,
// plus the state encoding of the multiplier-sharing arbiter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package elliptic_curve_structs;

    localparam int COORD_WIDTH  = 16;
    localparam int SCALAR_WIDTH = 16;

    typedef struct packed {
        logic [COORD_WIDTH-1:0] x;
        logic [COORD_WIDTH-1:0] y;
    } curve_point_t;

    // Point at infinity uses the all-zero encoding.
    localparam curve_point_t inf_point = '{x: '0, y: '0};

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_LAUNCH = 2'd1,
        ARB_WAIT   = 2'd2,
        ARB_RESP   = 2'd3
    } mul_arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//------------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter: priority starts at ptr and wraps.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
    parameter int  N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic          found;
    int            pos;
    logic [IW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = 0;
        idx       = '0;
        for (int i = 0; i < N; i++) begin
            pos = (int'(ptr) + i) % N;
            idx = IW'(pos);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/point_mul_arbiter.sv
//------------------------------------------------------------------------------
// point_mul_arbiter
// Shares one double-and-add point multiplier between NUM_REQ requesters.
// Optional watchdog on the multiplier wait: define MUL_ARB_TIMEOUT_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module point_mul_arbiter
    import elliptic_curve_structs::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int MAX_CYCLES = 4096
) (
    input  logic                                   clk,
    input  logic                                   Reset,
    input  logic [NUM_REQ-1:0]                     req_valid,
    output logic [NUM_REQ-1:0]                     req_ready,
    input  curve_point_t [NUM_REQ-1:0]             req_P,
    input  logic [NUM_REQ-1:0][SCALAR_WIDTH-1:0]   req_k,
    output logic [NUM_REQ-1:0]                     rsp_valid,
    input  logic [NUM_REQ-1:0]                     rsp_ready,
    output curve_point_t                           rsp_R,
    output logic                                   rsp_err,
    output logic                                   busy,
    output logic                                   mul_reset,
    output curve_point_t                           mul_P,
    output logic [SCALAR_WIDTH-1:0]                mul_k,
    input  curve_point_t                           mul_R,
    input  logic                                   mul_done
);

    localparam int IDX_W = $clog2(NUM_REQ);

    mul_arb_state_t     state, next_state;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   id;
    logic               first_wait;
    logic               req_fire;
    logic               done_ok;
    logic               timeout;
    logic               rsp_fire;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_fire = (state == ARB_IDLE) && !Reset && (|grant);
    // Done may still be high from the previous job in the first WAIT cycle.
    assign done_ok  = (state == ARB_WAIT) && !first_wait && mul_done;
    assign rsp_fire = (state == ARB_RESP) && rsp_ready[id];

`ifdef MUL_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    assign timeout = (state == ARB_WAIT) && !done_ok &&
                     (wait_cnt == CNT_W'(MAX_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (Reset) begin
            wait_cnt <= '0;
            rsp_err  <= 1'b0;
        end else begin
            if (state == ARB_LAUNCH) begin
                wait_cnt <= '0;
            end else if (state == ARB_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (timeout) begin
                rsp_err <= 1'b1;
            end else if (rsp_fire) begin
                rsp_err <= 1'b0;
            end
        end
    end
`else
    logic [31:0] unused_max_cycles;

    assign unused_max_cycles = 32'(MAX_CYCLES);
    assign timeout           = 1'b0;
    assign rsp_err           = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = '0;
        rsp_valid  = '0;
        mul_reset  = 1'b1;
        busy       = (state != ARB_IDLE);
        case (state)
            ARB_IDLE: begin
                req_ready = Reset ? '0 : grant;
                if (req_fire) begin
                    next_state = ARB_LAUNCH;
                end
            end
            ARB_LAUNCH: begin
                next_state = ARB_WAIT;
            end
            ARB_WAIT: begin
                mul_reset = 1'b0;
                if (done_ok || timeout) begin
                    next_state = ARB_RESP;
                end
            end
            ARB_RESP: begin
                rsp_valid[id] = 1'b1;
                if (rsp_fire) begin
                    next_state = ARB_IDLE;
                end
            end
            default: begin
                next_state = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            rr_ptr     <= '0;
            id         <= '0;
            mul_P      <= inf_point;
            mul_k      <= '0;
            rsp_R      <= inf_point;
            first_wait <= 1'b0;
        end else begin
            if (req_fire) begin
                mul_P  <= req_P[grant_idx];
                mul_k  <= req_k[grant_idx];
                id     <= grant_idx;
                rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (state == ARB_LAUNCH) begin
                first_wait <= 1'b1;
            end else if (state == ARB_WAIT) begin
                first_wait <= 1'b0;
            end
            if (done_ok) begin
                rsp_R <= mul_R;
            end else if (timeout) begin
                rsp_R <= inf_point;
            end
        end
    end

endmodule

`default_nettype wire
